digit_serial_subtractor: RTL and testbench
==========================================

# digit_serial_subtractor

Parametrised multi-digit subtractor computing {borrowOut, xy} = x − y − borrowIn over WIDTH bits, one DIGIT-bit slice per clock, with a single shared ripple-borrow slice and a registered borrow between slices. It is the sequential successor to the fixed 4-bit ripple subtractor. The block trades latency for area on wide operands, and adds a start/done handshake, optional unsigned saturation and a zero flag. It sits in the datapath wherever a WIDTH-bit difference is needed and a multi-cycle result is acceptable.

## Interface
- WIDTH, 16: operand and result width in bits. WIDTH must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle, DIGIT ≥ 1. NDIG = WIDTH/DIGIT.

- clk  input  1  clock. Every register updates on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- start  input  1  request a new subtraction. Accepted only when not busy.
- x  input  WIDTH  minuend. Sampled on the accepting edge.
- y  input  WIDTH  subtrahend. Sampled on the accepting edge.
- borrowIn  input  1  initial borrow. Sampled on the accepting edge.
- satMode  input  1  1 = clamp the result to 0 on final borrow. Sampled on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse: result is valid.
- xy  output  WIDTH  difference, after saturation if enabled.
- borrowOut  output  1  final borrow, before saturation.
- zero  output  1  xy == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset state is IDLE. All outputs are 0 in reset: busy=0, done=0, xy=0, borrowOut=0, zero=0.
- IDLE/DONE with start=1:
  - latch x, y, borrowIn and satMode into working registers;
  - set the digit index to 0;
  - go to RUN.
- IDLE/DONE with start=0:
  - go to (or stay in) IDLE;
  - xy, borrowOut and zero hold their values.
- RUN, digit index i:
  - compute slice i: {b, d} = x[i*DIGIT +: DIGIT] − y[i*DIGIT +: DIGIT] − borrowReg, with borrowReg initialised to borrowIn;
  - write d into working result slice i and b into borrowReg;
  - increment i.
- RUN, completion: when i == NDIG−1, on the same edge:
  - borrowOut ← b;
  - xy ← (satMode && b) ? 0 : full working result, including the new slice;
  - zero ← (xy_new == 0);
  - go to DONE.
- DONE lasts exactly one cycle with done=1.
- start during RUN is ignored: no latch, no effect on the operation in progress.
- start during the DONE cycle is accepted, giving back-to-back operations with no idle gap.
- xy, borrowOut and zero change only on the completion edge. During RUN they show the previous result.
- Arithmetic is unsigned modulo 2^WIDTH. borrowOut=1 iff x < y + borrowIn.
- Reset asserted at any time, including mid-RUN: the operation is abandoned, all state and outputs clear asynchronously, and the FSM returns to IDLE. No done pulse follows.

## Timing
- Accepting edge T0: start=1 sampled in IDLE/DONE.
- busy=1 from T0 up to the completion edge T0+NDIG, i.e. for NDIG cycles.
- done=1 for the single cycle after T0+NDIG. xy, borrowOut and zero are valid from that cycle.
- Latency from start to done is NDIG+1 edges.
- Throughput is one result per NDIG+1 cycles with back-to-back starts.
- The slice logic is one DIGIT-bit ripple borrow chain between registers, so the critical path scales with DIGIT, not WIDTH.
- busy and done are never high together.

## Test plan
- WIDTH=16, DIGIT=4: x=0x1234, y=0x0234, borrowIn=0 → after 4 busy cycles, done pulse with xy=0x1000, borrowOut=0, zero=0.
- Same config: x=0x0000, y=0x0001, satMode=0 → xy=0xFFFF, borrowOut=1. Repeat with satMode=1 → xy=0x0000, borrowOut=1, zero=1.
- Borrow propagation across every slice: x=0x8000, y=0x7FFF, borrowIn=1 → xy=0x0000, borrowOut=0, zero=1.
- Handshake:
  - pulse start with new operands on each of the 4 RUN cycles → no effect, and the original result is produced;
  - start held high in the DONE cycle → the second operation completes exactly 5 cycles after the first done.
- Reset mid-operation: assert nReset=0 during the 2nd RUN cycle → busy, done, xy, borrowOut and zero are 0 immediately, and no done pulse follows. A subsequent start works normally.
- WIDTH=8, DIGIT=1: x=0x05, y=0x07 → busy for 8 cycles, xy=0xFE, borrowOut=1. Also check DIGIT=WIDTH=8 (NDIG=1): done 2 edges after start.

Source files
------------

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//
// Multi-cycle unsigned subtractor: {borrowOut, xy} = x - y - borrowIn over
// WIDTH bits. One DIGIT-bit slice is handled per clock by a single shared
// ripple-borrow slice. The borrow between slices is held in a register.
// A start/done handshake controls the block. Optional unsigned saturation
// clamps the result to zero on a final borrow. A zero flag is also provided.
//
// Parameters
//   WIDTH     operand/result width; must be a multiple of DIGIT
//   DIGIT     bits processed per clock (>= 1); NDIG = WIDTH/DIGIT
//
// Ports
//   clk        in   rising-edge clock
//   nReset     in   asynchronous active-low reset
//   start      in   request a subtraction (ignored while busy)
//   x, y       in   minuend / subtrahend, sampled on the accepting edge
//   borrowIn   in   initial borrow, sampled on the accepting edge
//   satMode    in   clamp result to 0 on final borrow, sampled on accept
//   busy       out  high while digits are being processed (NDIG cycles)
//   done       out  one-cycle pulse, result valid
//   xy         out  difference (after optional saturation)
//   borrowOut  out  final borrow (before saturation)
//   zero       out  xy == 0
module digit_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrowIn,
  input  logic             satMode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] xy,
  output logic             borrowOut,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;       // operands shift right so slice i is always at [DIGIT-1:0]
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_sat;
  logic [IDX_W-1:0] r_idx;

  logic [DIGIT:0]   w_slice;
  logic [DIGIT-1:0] w_d;
  logic             w_b;
  logic [WIDTH-1:0] w_res_new;
  logic [WIDTH-1:0] w_xy_new;
  logic             w_last;

  // One DIGIT-bit ripple-borrow slice. The MSB of the result is the borrow out.
  function automatic logic [DIGIT:0] sub_slice(input logic [DIGIT-1:0] a,
                                                input logic [DIGIT-1:0] b,
                                                input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  endfunction

  // Unsigned saturation: an underflowing difference clamps to zero.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v,
                                                input logic             en,
                                                input logic             bout);
    return (en && bout) ? '0 : v;
  endfunction

  assign w_slice = sub_slice(r_x[DIGIT-1:0], r_y[DIGIT-1:0], r_borrow);
  assign w_d     = w_slice[DIGIT-1:0];
  assign w_b     = w_slice[DIGIT];
  assign w_last  = (r_idx == LAST_IDX);

  // The full working result including the slice being written this cycle,
  // so the completion edge can publish it directly.
  always_comb begin
    w_res_new = r_res;
    w_res_new[r_idx*DIGIT +: DIGIT] = w_d;
  end

  assign w_xy_new = saturate(w_res_new, r_sat, w_b);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_res     <= '0;
      r_borrow  <= 1'b0;
      r_sat     <= 1'b0;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      xy        <= '0;
      borrowOut <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_x      <= x;
            r_y      <= y;
            r_borrow <= borrowIn;
            r_sat    <= satMode;
            r_res    <= '0;
            r_idx    <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_x      <= r_x >> DIGIT;
          r_y      <= r_y >> DIGIT;
          r_borrow <= w_b;
          r_res    <= w_res_new;
          if (w_last) begin
            borrowOut <= w_b;
            xy        <= w_xy_new;
            zero      <= (w_xy_new == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor in three configurations:
// A = WIDTH 16 / DIGIT 4, B = WIDTH 8 / DIGIT 1, C = WIDTH 8 / DIGIT 8.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [2:0]  st = 3'b000;
  logic [15:0] tx = '0;
  logic [15:0] ty = '0;
  logic        tbi = 1'b0;
  logic        tsat = 1'b0;

  logic        busy_a, done_a, bo_a, z_a;
  logic [15:0] xy_a;
  logic        busy_b, done_b, bo_b, z_b;
  logic [7:0]  xy_b;
  logic        busy_c, done_c, bo_c, z_c;
  logic [7:0]  xy_c;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  logic        o_busy, o_done, o_bo, o_z;
  logic [15:0] o_xy;

  always #5 clk = ~clk;

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_a (
    .clk(clk), .nReset(nReset), .start(st[0]), .x(tx), .y(ty),
    .borrowIn(tbi), .satMode(tsat), .busy(busy_a), .done(done_a),
    .xy(xy_a), .borrowOut(bo_a), .zero(z_a));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_b (
    .clk(clk), .nReset(nReset), .start(st[1]), .x(tx[7:0]), .y(ty[7:0]),
    .borrowIn(tbi), .satMode(tsat), .busy(busy_b), .done(done_b),
    .xy(xy_b), .borrowOut(bo_b), .zero(z_b));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_c (
    .clk(clk), .nReset(nReset), .start(st[2]), .x(tx[7:0]), .y(ty[7:0]),
    .borrowIn(tbi), .satMode(tsat), .busy(busy_c), .done(done_c),
    .xy(xy_c), .borrowOut(bo_c), .zero(z_c));

  always_comb begin
    o_busy = busy_a; o_done = done_a; o_xy = xy_a; o_bo = bo_a; o_z = z_a;
    if (cur == 1) begin
      o_busy = busy_b; o_done = done_b; o_xy = {8'h00, xy_b}; o_bo = bo_b; o_z = z_b;
    end else if (cur == 2) begin
      o_busy = busy_c; o_done = done_c; o_xy = {8'h00, xy_c}; o_bo = bo_c; o_z = z_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation on DUT 'sel' and check busy for every RUN cycle,
  // then the done cycle and the results. Returns in the done cycle (#1 after edge).
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic sat, input logic [15:0] exp_xy,
                        input logic exp_bo, input logic exp_z, input string tag);
    int nd;
    cur = sel;
    nd = (sel == 0) ? 4 : (sel == 1) ? 8 : 1;
    tx = a; ty = b; tbi = bi; tsat = sat;
    st[sel] = 1'b1;
    @(posedge clk); #1;
    st = 3'b000;
    for (int k = 0; k < nd; k++) begin
      check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
      @(posedge clk); #1;
    end
    check({tag, "_done"},   {31'd0, o_done}, 32'd1);
    check({tag, "_nobusy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_xy"},     {16'd0, o_xy},   {16'd0, exp_xy});
    check({tag, "_bo"},     {31'd0, o_bo},   {31'd0, exp_bo});
    check({tag, "_zero"},   {31'd0, o_z},    {31'd0, exp_z});
  endtask

  initial begin
    int cnt;
    int pulses;

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_xy",   {16'd0, xy_a},   32'd0);
    check("rst_bo",   {31'd0, bo_a},   32'd0);
    check("rst_zero", {31'd0, z_a},    32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;
    @(posedge clk); #1;

    // Basic operations, WIDTH 16 / DIGIT 4
    run_op(0, 16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "a_basic");
    @(posedge clk); #1;
    check("a_done_pulse", {31'd0, done_a}, 32'd0);
    run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, "a_under");
    @(posedge clk); #1;
    run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "a_sat");
    @(posedge clk); #1;
    run_op(0, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "a_ripple");
    @(posedge clk); #1;

    // start pulsed with new operands during every RUN cycle is ignored
    cur = 0;
    tx = 16'h1234; ty = 16'h0234; tbi = 1'b0; tsat = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    tx = 16'hFFFF; ty = 16'h0000; tbi = 1'b1; tsat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("hs_run_xy_hold", {16'd0, xy_a}, 32'h0000);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    st[0] = 1'b0;
    check("hs_ign_done", {31'd0, done_a}, 32'd1);
    check("hs_ign_xy",   {16'd0, xy_a},   32'h1000);
    check("hs_ign_bo",   {31'd0, bo_a},   32'd0);

    // Back-to-back: start in the DONE cycle
    tx = 16'h00FF; ty = 16'h000F; tbi = 1'b0; tsat = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    cnt = 1;
    while (!done_a && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b2b_gap", cnt, 32'd5);
    check("b2b_xy",  {16'd0, xy_a}, 32'h00F0);

    @(posedge clk); #1;
    // Reset in the 2nd RUN cycle
    tx = 16'h0000; ty = 16'h0002; tbi = 1'b0; tsat = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy_a}, 32'd0);
    check("mrst_done", {31'd0, done_a}, 32'd0);
    check("mrst_xy",   {16'd0, xy_a},   32'd0);
    check("mrst_bo",   {31'd0, bo_a},   32'd0);
    check("mrst_zero", {31'd0, z_a},    32'd0);
    @(posedge clk); #3;
    nReset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) pulses++;
    end
    check("mrst_no_done", pulses, 32'd0);
    run_op(0, 16'h0010, 16'h0001, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, "a_after_rst");
    @(posedge clk); #1;

    // WIDTH 8 / DIGIT 1
    run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h00FE, 1'b1, 1'b0, "b_d1");
    @(posedge clk); #1;

    // WIDTH 8 / DIGIT 8 (single slice, done two edges after start)
    run_op(2, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h00FE, 1'b1, 1'b0, "c_d8");
    @(posedge clk); #1;
    run_op(2, 16'h00A0, 16'h000F, 1'b1, 1'b0, 16'h0090, 1'b0, 1'b0, "c_d8_bi");
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
